clsf_window_sched: RTL
======================

Name: clsf_window_sched

Overview:
- Controller that sequences the 24-row sliding-window pixel datapath and the classifier tree.
- Tracks column/row position of every pixel-pair beat entering the shift-register array and asserts the tree data-valid strobe only for complete windows.
- Tags each classifier result with its window coordinates after the tree latency.
- Generates frame start/done/abort events for the downstream result collector.

Parameters:
LINE_PIXELS, 184, pixels per image line
MOVE_STEP, 2, pixels per input beat (window step)
WIN_COLS, 12, window width in beats (24 pixels)
WIN_ROWS, 24, window height in lines (number of chained shift rows)
FRAME_LINES, 36, lines per frame
TREE_LAT, 4, cycles from tree data-valid to registered classifier result
(derived constant) BEATS_PER_LINE = LINE_PIXELS/MOVE_STEP = 92

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_start  in  1  single-cycle pulse marking the first beat of a frame
pix_valid  in  1  one pixel-pair beat enters the shift array this cycle
tree_valid  out  1  data-valid to the classifier tree, aligned with the registered window bus
clsf_in  in  4  classifier results {result3, result2, result1, result0}
res_valid  out  1  tagged result valid
res_class  out  4  classifier results captured when res_valid is high
res_x  out  7  window column index 0..BEATS_PER_LINE-WIN_COLS
res_y  out  6  window row index 0..FRAME_LINES-WIN_ROWS
busy  out  1  frame in progress (state not IDLE)
frame_done  out  1  one-cycle pulse after the last beat of a frame
frame_abort  out  1  one-cycle pulse when frame_start arrives mid-frame
win_count  out  11  windows issued in the current or last frame

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, tag pipeline cleared.
- Counters:
  - col_cnt runs 0..BEATS_PER_LINE-1. It increments on each accepted beat and wraps to 0 at 91.
  - row_cnt increments on each col_cnt wrap and runs 0..FRAME_LINES-1.
  - A beat is accepted when pix_valid=1 in FILL or SCAN, or when frame_start=1 and pix_valid=1 in any state (that beat is col 0, row 0).
- States:
  - IDLE: pix_valid is ignored. frame_start -> FILL, and counters load 0, or advance to col 1 if pix_valid is high the same cycle.
  - FILL: rows 0..WIN_ROWS-2. The accepted beat at col 91, row 22 moves to SCAN.
  - SCAN: window qualifies when col_cnt >= WIN_COLS-1. The accepted beat at col 91, row FRAME_LINES-1 moves to DONE.
  - DONE: one cycle. frame_done=1, then -> IDLE. In the same cycle, frame_start goes to FILL instead of IDLE and still pulses frame_done.
- tree_valid:
  - Registered, so it is high exactly one cycle after a qualifying accepted beat. This matches the one-cycle window bus register.
  - Coordinates tag: x = col_cnt-(WIN_COLS-1), y = row_cnt-(WIN_ROWS-1), captured with it.
- Tag pipeline:
  - TREE_LAT-deep shift of {valid, x, y}.
  - res_valid/res_x/res_y are the pipeline output. res_class samples clsf_in in the same cycle res_valid is asserted; otherwise it holds.
  - The pipeline keeps draining after DONE/IDLE.
- win_count: cleared on each frame_start and incremented per tree_valid. Saturates at 2047. Nominal value 81*13 = 1053.
- frame_start in FILL/SCAN:
  - frame_abort pulses one cycle and counters restart as in IDLE entry.
  - All pipeline valid bits are cleared the same edge, so no stale results emerge.
  - tree_valid from the prior beat is suppressed.
- pix_valid gaps: counters and state hold. There are no timeouts.
- Reset mid-frame: identical to the reset values above, and takes effect on the next edge.

Decomposition:
- Shared package holds:
  - geometry constants (LINE_PIXELS, MOVE_STEP, BEATS_PER_LINE, WIN_COLS, WIN_ROWS, FRAME_LINES, TREE_LAT)
  - state encoding (IDLE=0, FILL=1, SCAN=2, DONE=3)
  - coordinate widths
- One sub-module, clsf_tag_pipe: a parameterised depth/width valid+tag delay line with synchronous flush.
- FSM and counters stay in clsf_window_sched.

Test Plan:
- frame_start+pix_valid continuous for 3312 beats -> first tree_valid one cycle after beat index 2127 (col 11, row 23); first res_valid TREE_LAT later with x=0, y=0; last result x=80, y=12; win_count=1053; frame_done one cycle after beat 3311.
- Same frame with pix_valid toggled 1/0 every cycle -> identical tree_valid count, coordinates and order; no strobe on idle cycles.
- Drive clsf_in=4'b1010 when the first res_valid is high -> res_class=4'b1010 and holds until the next res_valid.
- frame_start at beat 2500 of a frame -> frame_abort pulse; no res_valid for TREE_LAT cycles of stale tags; new frame's first result is x=0, y=0 with win_count restarted.
- pix_valid in IDLE without frame_start -> no counter change, busy=0, no tree_valid.
- rst asserted during SCAN -> next cycle all outputs 0, state IDLE; the following frame_start produces a normal frame.

Source files
------------

// File: rtl/clsf_window_sched_pkg.sv
// Shared geometry, state encoding and tag layout for the sliding-window scheduler.
package clsf_window_sched_pkg;

    localparam int LINE_PIXELS    = 184;
    localparam int MOVE_STEP      = 2;
    localparam int BEATS_PER_LINE = LINE_PIXELS / MOVE_STEP;   // 92
    localparam int WIN_COLS       = 12;
    localparam int WIN_ROWS       = 24;
    localparam int FRAME_LINES    = 36;
    localparam int TREE_LAT       = 4;

    // Counter and coordinate widths
    localparam int COL_W = $clog2(BEATS_PER_LINE);   // 7
    localparam int ROW_W = $clog2(FRAME_LINES);      // 6
    localparam int X_W   = COL_W;
    localparam int Y_W   = ROW_W;
    localparam int CNT_W = 11;

    // Sized compare constants so counter comparisons stay width-matched
    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(BEATS_PER_LINE - 1);
    localparam logic [COL_W-1:0] COL_WIN_FIRST = COL_W'(WIN_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(FRAME_LINES - 1);
    localparam logic [ROW_W-1:0] ROW_FILL_LAST = ROW_W'(WIN_ROWS - 2);
    localparam logic [ROW_W-1:0] ROW_WIN_FIRST = ROW_W'(WIN_ROWS - 1);
    localparam logic [CNT_W-1:0] WIN_COUNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    // Window coordinates carried alongside each tree data-valid
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } win_tag_t;

endpackage

// File: rtl/clsf_tag_pipe.sv
// Fixed-depth valid+tag delay line; flush drops every valid bit (including the
// one being shifted in) on the same edge, while tags simply keep shifting.
module clsf_tag_pipe #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_tag,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_tag
);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] tag_q [DEPTH];

    // Shift valid and tag one stage per cycle; flush clears all valids
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            // NOTE: the tag stages are few and narrow, so they are reset too;
            // this keeps res_x/res_y at 0 out of reset instead of X.
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let each stage take its neighbour's
            // old value, so the loop direction has no effect on the result.
            for (int i = DEPTH - 1; i > 0; i--) begin
                vld_q[i] <= vld_q[i-1] & ~flush;
                tag_q[i] <= tag_q[i-1];
            end
            vld_q[0] <= in_valid & ~flush;
            tag_q[0] <= in_tag;
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/clsf_window_sched.sv
// Sliding-window scheduler: tracks beat position, issues tree data-valid for
// complete windows, tags classifier results with window coordinates and
// reports frame start/done/abort events.
module clsf_window_sched
    import clsf_window_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pix_valid,
    output logic        tree_valid,
    input  logic [3:0]  clsf_in,
    output logic        res_valid,
    output logic [3:0]  res_class,
    output logic [6:0]  res_x,
    output logic [5:0]  res_y,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_abort,
    output logic [10:0] win_count
);

    state_t           state;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    win_tag_t         tree_tag;
    win_tag_t         res_tag;

    logic in_frame;
    logic col_last;
    logic row_last;
    logic fill_last;
    logic win_ok;
    logic abort;

    assign in_frame  = (state == FILL) || (state == SCAN);
    assign col_last  = (col_cnt == COL_LAST);
    assign row_last  = (row_cnt == ROW_LAST);
    assign fill_last = (row_cnt == ROW_FILL_LAST);
    assign win_ok    = (state == SCAN) && (col_cnt >= COL_WIN_FIRST);
    assign abort     = frame_start && in_frame;
    assign busy      = (state != IDLE);

    // Frame FSM, beat position counters, tree strobe/tag and event pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            col_cnt     <= '0;
            row_cnt     <= '0;
            tree_valid  <= 1'b0;
            tree_tag    <= '0;
            win_count   <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            tree_valid  <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            if (frame_start) begin
                // A start beat is col 0, row 0 and never completes a window
                state       <= FILL;
                col_cnt     <= pix_valid ? COL_W'(1) : '0;
                row_cnt     <= '0;
                win_count   <= '0;
                frame_abort <= in_frame;
            end else begin
                case (state)
                    FILL, SCAN: begin
                        if (pix_valid) begin
                            col_cnt <= col_last ? '0 : col_cnt + 1'b1;
                            if (col_last) begin
                                row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                            end
                            if (win_ok) begin
                                tree_valid <= 1'b1;
                                tree_tag.x <= col_cnt - COL_WIN_FIRST;
                                tree_tag.y <= row_cnt - ROW_WIN_FIRST;
                                if (win_count != WIN_COUNT_MAX) begin
                                    win_count <= win_count + 1'b1;
                                end
                            end
                            if (state == FILL && col_last && fill_last) begin
                                state <= SCAN;
                            end
                            if (state == SCAN && col_last && row_last) begin
                                state      <= DONE;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Delay the window tag by the classifier tree latency
    clsf_tag_pipe #(
        .DEPTH (TREE_LAT),
        .WIDTH ($bits(win_tag_t))
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .in_valid  (tree_valid),
        .in_tag    (tree_tag),
        .out_valid (res_valid),
        .out_tag   (res_tag)
    );

    assign res_x = res_tag.x;
    assign res_y = res_tag.y;

    // Capture the classifier result while its tag is presented; hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            res_class <= '0;
        end else if (res_valid) begin
            res_class <= clsf_in;
        end
    end

endmodule
